// File: rtl/tpu_sequencer.sv
// tpu_sequencer: control FSM for the 4x4 TPU operand load, systolic run and result writeback
module tpu_sequencer #(
  parameter int N = 4,
  parameter int DW = 4,
  parameter int FEED_DIV = 4,
  parameter int RUN_STEPS = 17
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_a,
  input  logic [DW-1:0] load_b,
  output logic          load_ready,
  output logic [4:0]    ram_addr,
  output logic          ram_wr_a,
  output logic          ram_wr_b,
  output logic          wb_sel,
  output logic [3:0]    res_idx,
  output logic [1:0]    demux_sel,
  output logic          sys_en,
  output logic          sys_clr,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state
);
  localparam int NN = N * N;
  localparam int DVW = $clog2(FEED_DIV + 1);
  localparam int STW = $clog2(RUN_STEPS + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, WB = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [3:0] acc_q, acc_d, wb_q, wb_d, ra_q, ra_d;
  logic [DVW-1:0] div_q, div_d;
  logic [STW-1:0] step_q, step_d;
  logic step_hit;
  logic unused_load;
  assign unused_load = ^{load_a, load_b};
  assign state = state_q;
  assign step_hit = state_q == RUN && div_q == DVW'(FEED_DIV - 1);
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      acc_q <= '0;
      wb_q <= '0;
      ra_q <= '0;
      div_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      wb_q <= wb_d;
      ra_q <= ra_d;
      div_q <= div_d;
      step_q <= step_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    wb_d = wb_q;
    ra_d = ra_q;
    div_d = div_q;
    step_d = step_q;
    load_ready = state_q == LOAD;
    busy = state_q != IDLE;
    done = state_q == DONE;
    wb_sel = state_q == WB;
    ram_wr_a = (state_q == LOAD && load_valid) || state_q == WB;
    ram_wr_b = state_q == LOAD && load_valid;
    res_idx = state_q == WB ? wb_q : 4'd0;
    ram_addr = {1'b0, state_q == LOAD ? acc_q : state_q == RUN ? ra_q : state_q == WB ? wb_q : 4'd0};
    demux_sel = state_q == RUN ? ra_q[1:0] : 2'd0;
    sys_en = step_hit;
    sys_clr = state_q == RUN && div_q == '0 && step_q == '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        acc_d = '0;
      end
      LOAD: if (load_valid) begin
        acc_d = acc_q + 4'd1;
        if (acc_q == 4'(NN - 1)) begin
          state_d = RUN;
          div_d = '0;
          step_d = '0;
          ra_d = '0;
        end
      end
      RUN: begin
        ra_d = ra_q + 4'd1;
        div_d = step_hit ? '0 : div_q + 1'b1;
        if (step_hit) begin
          step_d = step_q + 1'b1;
          if (step_q == STW'(RUN_STEPS - 1)) begin
            state_d = WB;
            wb_d = '0;
          end
        end
      end
      WB: begin
        wb_d = wb_q + 4'd1;
        if (wb_q == 4'(NN - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: scoreboard bench for tpu_sequencer job timing, stalls, abort and start handling
module tb_tpu_sequencer;
  logic clk = 0, res = 1, start = 0, load_valid = 0;
  logic [3:0] load_a = 0, load_b = 0;
  logic load_ready, ram_wr_a, ram_wr_b, wb_sel, sys_en, sys_clr, busy, done;
  logic [4:0] ram_addr;
  logic [3:0] res_idx;
  logic [1:0] demux_sel;
  logic [2:0] state;
  logic [21:0] outs;
  int cyc = 0, total = 0, bad = 0;
  bit mon_on = 0;
  typedef struct {int cyc; int addr; bit wb;} ev_t;
  ev_t q_wr[$], q_en[$];
  int q_clr[$], q_done[$];
  tpu_sequencer dut (
    .clk(clk), .res(res), .start(start), .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
    .load_ready(load_ready), .ram_addr(ram_addr), .ram_wr_a(ram_wr_a), .ram_wr_b(ram_wr_b),
    .wb_sel(wb_sel), .res_idx(res_idx), .demux_sel(demux_sel), .sys_en(sys_en), .sys_clr(sys_clr),
    .busy(busy), .done(done), .state(state)
  );
  assign outs = {load_ready, ram_addr, ram_wr_a, ram_wr_b, wb_sel, res_idx, demux_sel, sys_en, sys_clr, busy, done, state};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s at cyc %0d: got event want none", nm, cyc);
  endtask
  always @(negedge clk) if (mon_on) begin
    ev_t e;
    if (ram_wr_a || ram_wr_b) begin
      if (q_wr.size() == 0) unexpected("wr_unexpected");
      else begin
        e = q_wr.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", ram_addr, e.addr);
        chk("wr_ctl", {ram_wr_a, ram_wr_b, wb_sel, res_idx}, {1'b1, !e.wb, e.wb, e.wb ? 4'(e.addr) : 4'd0});
      end
    end
    if (sys_en) begin
      if (q_en.size() == 0) unexpected("en_unexpected");
      else begin
        e = q_en.pop_front();
        chk("en_cyc", cyc, e.cyc);
        chk("en_addr", {ram_addr, demux_sel}, {5'(e.addr), 2'(e.addr)});
      end
    end
    if (sys_clr) begin
      if (q_clr.size() == 0) unexpected("clr_unexpected");
      else chk("clr_cyc", cyc, q_clr.pop_front());
    end
    if (done) begin
      if (q_done.size() == 0) unexpected("done_unexpected");
      else begin
        chk("done_cyc", cyc, q_done.pop_front());
        chk("done_busy", busy, 1);
      end
    end
  end
  task automatic push_job(input int base, input int g, input int lim);
    int c;
    for (int k = 0; k < 16; k++) begin
      c = k + 1 + (k >= 5 ? g : 0);
      if (c <= lim) q_wr.push_back('{base + c - 1, k, 1'b0});
    end
    if (17 + g <= lim) q_clr.push_back(base + 16 + g);
    for (int i = 0; i < 17; i++) begin
      c = 20 + g + 4 * i;
      if (c <= lim) q_en.push_back('{base + c - 1, (3 + 4 * i) & 15, 1'b0});
    end
    for (int j = 0; j < 16; j++) begin
      c = 85 + g + j;
      if (c <= lim) q_wr.push_back('{base + c - 1, j, 1'b1});
    end
    if (101 + g <= lim) q_done.push_back(base + 100 + g);
  endtask
  task automatic run_job(input int g, input int abort_c, input bit poke, input bit hold);
    int base, k, last;
    last = abort_c > 0 ? abort_c + 1 : 101 + g;
    @(posedge clk); #1;
    start = 1;
    base = cyc + 1;
    push_job(base, g, abort_c > 0 ? abort_c : 1000);
    load_valid = 1;
    load_a = 0;
    load_b = 15;
    k = 0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      if (g > 0 && n >= 6 && n < 6 + g) chk("stall_hold", {load_ready, ram_addr}, {1'b1, 5'd5});
      if (abort_c > 0 && n == abort_c + 1) chk("abort_idle", outs, 0);
      start = hold || (poke && (n == 3 || n == 30 || n == 101 + g));
      res = abort_c > 0 && n == abort_c;
      if (n <= 16 + g && !(n >= 6 && n < 6 + g)) begin
        load_valid = 1;
        load_a = 4'(k);
        load_b = 4'(15 - k);
        k++;
      end else load_valid = 0;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    res = 0;
    mon_on = 1;
    load_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outs", outs, 0);
    end
    load_valid = 0;
    run_job(0, 0, 0, 0);
    start = 0;
    run_job(3, 0, 0, 0);
    start = 0;
    run_job(0, 40, 0, 0);
    repeat (5) @(posedge clk);
    run_job(0, 0, 0, 0);
    start = 0;
    run_job(0, 0, 1, 0);
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("done_start_ignored", {state, busy}, 0);
    run_job(0, 0, 0, 1);
    run_job(0, 0, 0, 1);
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("wr_left", q_wr.size(), 0);
    chk("en_left", q_en.size(), 0);
    chk("clr_left", q_clr.size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("final_idle", outs, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
